// File: rtl/instruction_queue.sv
// Prefetch queue between the instruction processor and the execute stage.
// Holds fetched instructions with their ROM addresses; flushed on an ip write.
module instruction_queue #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-2:0] NOP   = 15'b1_0000_1011_00_00_00
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-2:0]           instructionIn,
  input  logic [WIDTH-1:0]           addressIn,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic                       flush,
  output logic [WIDTH-2:0]           instructionOut,
  output logic [WIDTH-1:0]           addressOut,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 2 * WIDTH - 1;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;
  logic [EntryW-1:0] head;

  // Full/empty come from the registered count only, so inReady never
  // depends on outReady and pointer equality is never ambiguous.
  assign inReady  = (count_q != CntW'(DEPTH));
  assign outValid = (count_q != '0);
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; contents are only observed while counted valid.
  always_ff @(posedge clock) begin
    if (push && !flush && !reset) begin
      mem_q[wptr_q] <= {instructionIn, addressIn};
    end
  end

  assign head           = mem_q[rptr_q];
  assign instructionOut = outValid ? head[EntryW-1:WIDTH] : NOP;
  assign addressOut     = outValid ? head[WIDTH-1:0] : '0;
  assign count          = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Scoreboard bench for instruction_queue: a reference queue is updated from
// the driven stimulus and every consumed head entry is compared against it.
module tb_instruction_queue;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam logic [14:0] NOP_EXP = 15'b100001011000000;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] instructionIn;
  logic [15:0] addressIn;
  logic        inValid;
  logic        inReady;
  logic        flush;
  logic [14:0] instructionOut;
  logic [15:0] addressOut;
  logic        outValid;
  logic        outReady;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  bit mon_en   = 1'b0;
  bit seen_ff  = 1'b0;

  logic [30:0] sb[$];

  instruction_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .instructionIn  (instructionIn),
    .addressIn      (addressIn),
    .inValid        (inValid),
    .inReady        (inReady),
    .flush          (flush),
    .instructionOut (instructionOut),
    .addressOut     (addressOut),
    .outValid       (outValid),
    .outReady       (outReady),
    .count          (count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [14:0] ins, input logic [15:0] adr);
    inValid       = v;
    instructionIn = ins;
    addressIn     = adr;
  endtask

  // Reference model: outputs checked mid-cycle, then the model takes the edge.
  always @(negedge clock) begin
    if (mon_en) begin
      int sz;
      bit exp_pop;
      logic [30:0] exp_head;
      sz = sb.size();
      check_val("m_count", 32'(count), 32'(sz));
      check_val("m_outValid", 32'(outValid), 32'(sz != 0));
      check_val("m_inReady", 32'(inReady), 32'(sz != DEPTH));
      if (outValid && addressOut == 16'h00FF) seen_ff = 1'b1;
      if (sz == 0) begin
        check_val("m_nop", 32'(instructionOut), 32'(NOP_EXP));
        check_val("m_addr0", 32'(addressOut), 32'h0);
      end
      if (reset || flush) begin
        sb.delete();
      end else begin
        exp_pop = (sz != 0) && outReady;
        if (exp_pop) begin
          exp_head = sb.pop_front();
          check_val("pop_instr", 32'(instructionOut), 32'(exp_head[30:16]));
          check_val("pop_addr", 32'(addressOut), 32'(exp_head[15:0]));
          n_pops++;
        end
        if (inValid && sz != DEPTH) sb.push_back({instructionIn, addressIn});
      end
    end
  end

  initial begin
    int pops0;
    reset = 1'b1;
    flush = 1'b0;
    outReady = 1'b0;
    drive(1'b0, 15'h0, 16'h0);
    cyc();
    mon_en = 1'b1;
    cyc();
    reset = 1'b0;

    // 1: idle after reset
    cyc();
    check_val("t1_outValid", 32'(outValid), 32'h0);
    check_val("t1_nop", 32'(instructionOut), 32'(NOP_EXP));
    check_val("t1_addr", 32'(addressOut), 32'h0);
    check_val("t1_inReady", 32'(inReady), 32'h1);
    check_val("t1_count", 32'(count), 32'h0);

    // 2: two pushes, one pop
    drive(1'b1, 15'h1234, 16'd0);
    cyc();
    check_val("t2_latency", 32'(addressOut), 32'h0);
    check_val("t2_count1", 32'(count), 32'd1);
    drive(1'b1, 15'h0ABC, 16'd1);
    cyc();
    drive(1'b0, 15'h0, 16'h0);
    check_val("t2_count", 32'(count), 32'd2);
    check_val("t2_head_i", 32'(instructionOut), 32'h1234);
    check_val("t2_head_a", 32'(addressOut), 32'h0);
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
    check_val("t2_head2_i", 32'(instructionOut), 32'h0ABC);
    check_val("t2_head2_a", 32'(addressOut), 32'h1);
    check_val("t2_count2", 32'(count), 32'd1);
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;

    // 3: fill, refused push, drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 15'($urandom), 16'(10 + i));
      cyc();
    end
    check_val("t3_full_ready", 32'(inReady), 32'h0);
    check_val("t3_full_count", 32'(count), 32'd4);
    drive(1'b1, 15'h7777, 16'd14);
    cyc();
    drive(1'b0, 15'h0, 16'h0);
    check_val("t3_refused", 32'(count), 32'd4);
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("t3_order", 32'(addressOut), 32'(10 + i));
      cyc();
    end
    outReady = 1'b0;
    check_val("t3_empty", 32'(outValid), 32'h0);

    // 4: streaming with outReady held, pointers wrap several times
    pops0 = n_pops;
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 15'($urandom), 16'(i));
      cyc();
      check_val("t4_count", 32'(count), 32'd1);
      check_val("t4_head", 32'(addressOut), 32'(i));
    end
    drive(1'b0, 15'h0, 16'h0);
    cyc();
    outReady = 1'b0;
    check_val("t4_pops", 32'(n_pops - pops0), 32'd20);

    // 5: flush with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 15'($urandom), 16'(16'h0100 + i));
      cyc();
    end
    drive(1'b1, 15'h5555, 16'h00FF);
    flush = 1'b1;
    outReady = 1'b1;
    cyc();
    flush = 1'b0;
    outReady = 1'b0;
    drive(1'b0, 15'h0, 16'h0);
    check_val("t5_count", 32'(count), 32'h0);
    check_val("t5_outValid", 32'(outValid), 32'h0);
    check_val("t5_nop", 32'(instructionOut), 32'(NOP_EXP));
    outReady = 1'b1;
    repeat (3) cyc();
    outReady = 1'b0;
    check_val("t5_no_ff", 32'(seen_ff), 32'h0);

    // 6: reset mid-operation with a pending push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 15'($urandom), 16'(16'h0200 + i));
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b0, 15'h0, 16'h0);
    check_val("t6_count", 32'(count), 32'h0);
    check_val("t6_inReady", 32'(inReady), 32'h1);
    check_val("t6_outValid", 32'(outValid), 32'h0);
    drive(1'b1, 15'h2A2A, 16'hBEEF);
    cyc();
    drive(1'b0, 15'h0, 16'h0);
    check_val("t6_after_v", 32'(outValid), 32'h1);
    check_val("t6_after_i", 32'(instructionOut), 32'h2A2A);
    check_val("t6_after_a", 32'(addressOut), 32'hBEEF);
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
    cyc();
    check_val("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
- Prefetch queue directly downstream of the instruction processor: captures each fetched 15-bit instruction with the 16-bit ROM address it came from.
- Buffers up to DEPTH entries and presents them in order to the execute stage over a valid/ready handshake.
- Back-pressures the fetch side when full.
- Flushed when the ip register is written (branch/jump), discarding wrong-path instructions.

Parameters:
- WIDTH, 16, machine word width; instruction width is WIDTH-1, address width is WIDTH.
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- NOP, 15'b1_0000_1011_00_00_00, instruction presented on instructionOut while the queue is empty.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- instructionIn  input  WIDTH-1  instruction from the instruction processor.
- addressIn  input  WIDTH  ROM address the instruction was fetched from.
- inValid  input  1  instructionIn/addressIn hold a valid fetch this cycle.
- inReady  output  1  queue accepts a push this cycle.
- flush  input  1  discard all entries (driven from ip write, regChoose[7]).
- instructionOut  output  WIDTH-1  head-of-queue instruction.
- addressOut  output  WIDTH  head-of-queue address.
- outValid  output  1  head entry is valid.
- outReady  input  1  execute stage consumes head this cycle.
- count  output  $clog2(DEPTH)+1  current number of stored entries.

Behaviour:
- Reset (synchronous, active-high): read/write pointers = 0, count = 0, outValid = 0, inReady = 1, instructionOut = NOP, addressOut = 0. Storage contents are don't-care. Reset asserted mid-operation discards everything on that edge; reset has priority over flush, push and pop.
- Push: occurs when inValid && inReady. Writes {instructionIn, addressIn} at write pointer; write pointer increments modulo DEPTH.
- Pop: occurs when outValid && outReady. Read pointer increments modulo DEPTH.
- inReady = (count != DEPTH). Purely from registered state; no combinational path from outReady. Push into a full queue is refused even if a pop occurs in the same cycle.
- outValid = (count != 0), registered-state based.
- Show-ahead head output: instructionOut = storage[read pointer] and addressOut = its address when outValid. When !outValid, instructionOut = NOP and addressOut = 0.
- Latency: an instruction pushed at edge N is visible on instructionOut after edge N, so it is consumable in cycle N+1. No same-cycle bypass from instructionIn to instructionOut, including when empty.
- Simultaneous push and pop, 0 < count < DEPTH: both happen; count unchanged.
- Simultaneous push and pop at count = 0: no pop (outValid = 0); push happens; count becomes 1.
- count updates: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- Flush (not in reset): on that edge pointers and count return to 0. Any same-cycle push and pop are ignored, so the instruction on instructionIn that cycle is dropped. outValid = 0 from the next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by count, never by pointer equality alone.

Test Plan:
1. Reset then idle → outValid=0, instructionOut=15'b100001011000000, addressOut=0, inReady=1, count=0.
2. Push 0x1234@addr 0, 0x0ABC@addr 1 with outReady=0 → count=2; head shows 0x1234/0; after one pop, head shows 0x0ABC/1, count=1.
3. Fill DEPTH=4 entries (addr 10..13) with outReady=0 → inReady=0 at count=4. A 5th push (addr 14) is refused and count stays 4. Drain 4 pops → addresses 10,11,12,13 in order, then outValid=0.
4. Stream 20 consecutive pushes (addr 0..19) with outReady=1 permanently → count stays at 1 after the first edge. All 20 emerge in order with one-cycle latency, covering pointer wrap ≥4 times.
5. Queue holds 3 entries; assert flush together with inValid (addr 0x00FF) and outReady → next cycle count=0, outValid=0, instructionOut=NOP, and 0x00FF never appears.
6. Reset asserted while count=3 and a push is pending → next cycle count=0, inReady=1, outValid=0. A following push is visible after one edge.
